// File: rtl/pong_paddle_ctrl_if.sv
// Paddle controller signal bundle: per-frame inputs toward the conditioner
// and the conditioned paddle position back toward the pong core.
interface pong_paddle_ctrl_if;
  logic        vsync;
  logic [1:0]  mode;
  logic [15:0] analog;
  logic [7:0]  paddle;
  logic        dig_up;
  logic        dig_down;
  logic [7:0]  vpos;
  logic        dig_active;

  modport master (
    output vsync, mode, analog, paddle, dig_up, dig_down,
    input  vpos, dig_active
  );

  modport slave (
    input  vsync, mode, analog, paddle, dig_up, dig_down,
    output vpos, dig_active
  );
endinterface

// File: rtl/pong_paddle_ctrl.sv
// Per-player paddle input conditioner for the pong core.
// Once per vsync rising edge: capture the selected source, then slew-limit
// vpos toward it, or let digital buttons drive it with hold-to-accelerate.
// Build option: define PADDLE_DIGITAL_EN to compile in the digital button
// path, acceleration and release logic; otherwise buttons are ignored and
// dig_active is tied low.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for vsync rising edge
// CAPTURE | register target and button levels
// STEP    | compute new vpos / hold_cnt / dig_active
module pong_paddle_ctrl #(
  parameter int MAX_STEP      = 16,
  parameter int RELEASE_DELTA = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  pong_paddle_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STEP    = 2'd2
  } state_t;

  // Limits above 255 can never be exceeded by an 8-bit distance, so they
  // collapse to "no limit" (step) or "never release" (delta).
  localparam logic [7:0] STEP_LIM = 8'((MAX_STEP > 255) ? 0 : MAX_STEP);
  localparam logic [8:0] REL_LIM  = 9'((RELEASE_DELTA > 255) ? 255 : RELEASE_DELTA);

  state_t     state;
  logic       vsync_q;
  logic       vs_rise;
  logic [7:0] target;
  logic [7:0] tgt_q;
  logic [7:0] vpos_r;
  logic [8:0] diff;
  logic [8:0] diff_abs;
  logic [7:0] slew_vpos;

  assign vs_rise = pif.vsync & ~vsync_q;

  // Source mapping; sums wrap modulo 256.
  always_comb begin
    target = pif.paddle;
    case (pif.mode)
      2'd0:    target = pif.analog[15:8] + 8'h80;
      2'd1:    target = pif.analog[7:0] + 8'h80;
      2'd2:    target = pif.analog[7:0] ^ 8'h7F;
      default: target = pif.paddle;
    endcase
  end

  // Analog slew toward the captured target; diff bit 8 is the sign.
  always_comb begin
    diff      = {1'b0, tgt_q} - {1'b0, vpos_r};
    diff_abs  = diff[8] ? (~diff + 9'd1) : diff;
    slew_vpos = tgt_q;
    if ((STEP_LIM != 8'd0) && (diff_abs > {1'b0, STEP_LIM}))
      slew_vpos = diff[8] ? (vpos_r - STEP_LIM) : (vpos_r + STEP_LIM);
  end

`ifdef PADDLE_DIGITAL_EN
  logic       up_q;
  logic       down_q;
  logic       dig_active_r;
  logic [4:0] hold_cnt;
  logic [7:0] latch_tgt;
  logic [3:0] dig_step;
  logic [8:0] dn_sum;
  logic [7:0] dig_vpos;
  logic [8:0] rel_diff;
  logic [8:0] rel_abs;
  logic       one_btn;
  logic       release_ok;

  // Accelerating, saturating button step and the analog take-back test.
  always_comb begin
    dig_step = (hold_cnt < 5'd8) ? 4'd2 : ((hold_cnt < 5'd16) ? 4'd4 : 4'd8);
    dn_sum   = {1'b0, vpos_r} + {5'd0, dig_step};
    if (down_q)
      dig_vpos = dn_sum[8] ? 8'hFF : dn_sum[7:0];
    else
      dig_vpos = (vpos_r < {4'd0, dig_step}) ? 8'h00 : (vpos_r - {4'd0, dig_step});
    one_btn    = up_q ^ down_q;
    rel_diff   = {1'b0, tgt_q} - {1'b0, latch_tgt};
    rel_abs    = rel_diff[8] ? (~rel_diff + 9'd1) : rel_diff;
    release_ok = ~up_q & ~down_q & (rel_abs > REL_LIM);
  end

  assign pif.dig_active = dig_active_r;
`else
  logic unused_dig;
  assign unused_dig     = pif.dig_up ^ pif.dig_down;
  assign pif.dig_active = 1'b0;
`endif

  assign pif.vpos = vpos_r;

  // Frame sequencer: one capture and one position update per vsync rise.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= IDLE;
      vsync_q      <= 1'b0;
      tgt_q        <= 8'h80;
      vpos_r       <= 8'h80;
`ifdef PADDLE_DIGITAL_EN
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      dig_active_r <= 1'b0;
      hold_cnt     <= 5'd0;
      latch_tgt    <= 8'h80;
`endif
    end else begin
      vsync_q <= pif.vsync;
      case (state)
        IDLE: begin
          if (vs_rise) state <= CAPTURE;
        end
        CAPTURE: begin
          tgt_q  <= target;
`ifdef PADDLE_DIGITAL_EN
          up_q   <= pif.dig_up;
          down_q <= pif.dig_down;
`endif
          state  <= STEP;
        end
        STEP: begin
`ifdef PADDLE_DIGITAL_EN
          if (one_btn) begin
            dig_active_r <= 1'b1;
            latch_tgt    <= tgt_q;
            hold_cnt     <= (hold_cnt == 5'd31) ? hold_cnt : (hold_cnt + 5'd1);
            vpos_r       <= dig_vpos;
          end else begin
            hold_cnt <= 5'd0;
            // Digital owner keeps vpos until analog moves far enough away.
            if (!dig_active_r || release_ok) begin
              dig_active_r <= 1'b0;
              vpos_r       <= slew_vpos;
            end
          end
`else
          vpos_r <= slew_vpos;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
